// File: rtl/alarm_clock_s00_axi.sv
// AXI4-Lite slave with four R/W control registers for the alarm clock core.
// Write commits on the cycle of the second of AW/W; B and R responses wait for their READY.
module alarm_clock_s00_axi #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3
);

   localparam int ADDR_LSB = 2;
   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [1:0]                    w_state;
   logic                          aw_rdy;
   logic                          w_rdy;
   logic                          b_vld;
   logic [1:0]                    aw_idx_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]             wstrb_q;

   logic [0:0]                    r_state;
   logic                          ar_rdy;
   logic                          r_vld;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

   logic                          aw_hs;
   logic                          w_hs;
   logic                          b_hs;
   logic                          ar_hs;
   logic                          r_hs;
   logic [1:0]                    aw_idx_in;
   logic [1:0]                    ar_idx_in;

   logic                          wr_en;
   logic [1:0]                    wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]             wr_strb;

   logic                          unused_ok;

   assign aw_hs     = S_AXI_AWVALID & aw_rdy;
   assign w_hs      = S_AXI_WVALID  & w_rdy;
   assign b_hs      = b_vld & S_AXI_BREADY;
   assign ar_hs     = S_AXI_ARVALID & ar_rdy;
   assign r_hs      = r_vld & S_AXI_RREADY;
   assign aw_idx_in = S_AXI_AWADDR[ADDR_LSB +: 2];
   assign ar_idx_in = S_AXI_ARADDR[ADDR_LSB +: 2];

   // Commit takes the live payload of whichever channel completes last, the held one otherwise.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = aw_idx_q;
      wr_data = wdata_q;
      wr_strb = wstrb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_en   = 1'b1;
               wr_idx  = aw_idx_in;
               wr_data = S_AXI_WDATA;
               wr_strb = S_AXI_WSTRB;
            end
         end
         W_HALF: begin
            if (aw_hs) begin
               wr_en  = 1'b1;
               wr_idx = aw_idx_in;
            end else if (w_hs) begin
               wr_en   = 1'b1;
               wr_data = S_AXI_WDATA;
               wr_strb = S_AXI_WSTRB;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state  <= W_IDLE;
         aw_rdy   <= 1'b0;
         w_rdy    <= 1'b0;
         b_vld    <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  aw_rdy  <= 1'b0;
                  w_rdy   <= 1'b0;
                  b_vld   <= 1'b1;
                  w_state <= W_RESP;
               end else if (aw_hs) begin
                  aw_idx_q <= aw_idx_in;
                  aw_rdy   <= 1'b0;
                  w_rdy    <= 1'b1;
                  w_state  <= W_HALF;
               end else if (w_hs) begin
                  wdata_q <= S_AXI_WDATA;
                  wstrb_q <= S_AXI_WSTRB;
                  w_rdy   <= 1'b0;
                  aw_rdy  <= 1'b1;
                  w_state <= W_HALF;
               end else begin
                  aw_rdy <= 1'b1;
                  w_rdy  <= 1'b1;
               end
            end
            W_HALF: begin
               if (aw_hs || w_hs) begin
                  aw_rdy  <= 1'b0;
                  w_rdy   <= 1'b0;
                  b_vld   <= 1'b1;
                  w_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  b_vld   <= 1'b0;
                  aw_rdy  <= 1'b1;
                  w_rdy   <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: begin
               aw_rdy  <= 1'b0;
               w_rdy   <= 1'b0;
               b_vld   <= 1'b0;
               w_state <= W_IDLE;
            end
         endcase
      end
   end

   // Read captures the flop value, so a same-edge write is not visible to it.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= R_IDLE;
         ar_rdy  <= 1'b0;
         r_vld   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q <= regs[ar_idx_in];
                  r_vld   <= 1'b1;
                  ar_rdy  <= 1'b0;
                  r_state <= R_DATA;
               end else begin
                  ar_rdy <= 1'b1;
               end
            end
            default: begin
               if (r_hs) begin
                  r_vld   <= 1'b0;
                  ar_rdy  <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
         endcase
      end
   end

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = w_rdy;
   assign S_AXI_BVALID  = b_vld;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = r_vld;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   assign slv_reg0 = regs[0];
   assign slv_reg1 = regs[1];
   assign slv_reg2 = regs[2];
   assign slv_reg3 = regs[3];

   assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_alarm_clock_s00_axi.sv
// Scoreboard bench for alarm_clock_s00_axi: B/R expectations queued at issue, popped on handshake.
module tb_alarm_clock_s00_axi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

   int total = 0;
   int bad = 0;
   logic [31:0] mdl [4];
   logic [1:0]  bq [$];
   logic [31:0] rq [$];

   always #5 clk = ~clk;

   alarm_clock_s00_axi dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Outputs are stable at the falling edge; a valid&ready seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else chk("bresp", {30'd0, bresp}, {30'd0, bq.pop_front()});
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
               chk("rdata", rdata, rq.pop_front());
               chk("rresp", {30'd0, rresp}, 32'd0);
            end
         end
      end
   end

   task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         if (strb[b]) mdl[addr[3:2]][b*8 +: 8] = data[b*8 +: 8];
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit aw_done = 0, w_done = 0, aw_hit, w_hit;
      int n = 0;
      model_write(addr, data, strb);
      bq.push_back(2'b00);
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge clk);
         aw_hit = awvalid && awready;
         w_hit  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hit) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hit)  begin wvalid = 1'b0;  w_done = 1;  end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
   endtask

   task automatic axi_read(input logic [3:0] addr);
      bit done = 0, hit;
      int n = 0;
      rq.push_back(mdl[addr[3:2]]);
      araddr = addr; arvalid = 1'b1;
      while (!done && n < 50) begin
         @(negedge clk);
         hit = arvalid && arready;
         @(posedge clk); #1;
         if (hit) begin arvalid = 1'b0; done = 1; end
         n++;
      end
      arvalid = 1'b0;
      chk("rd_handshake", {31'd0, done}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain", bq.size() + rq.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mdl[i] = '0;

      // reset values
      @(posedge clk); #1;
      chk("rst_awready", {31'd0, awready}, 32'd0);
      chk("rst_wready", {31'd0, wready}, 32'd0);
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_reg0", slv_reg0, 32'd0);
      chk("rst_reg3", slv_reg3, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_awready", {31'd0, awready}, 32'd1);
      chk("post_rst_wready", {31'd0, wready}, 32'd1);
      chk("post_rst_arready", {31'd0, arready}, 32'd1);

      // sequential write then read-back
      for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
      drain();
      chk("seq_reg0", slv_reg0, 32'h1);
      chk("seq_reg1", slv_reg1, 32'h2);
      chk("seq_reg2", slv_reg2, 32'h3);
      chk("seq_reg3", slv_reg3, 32'h4);

      // AW at cycle 0, W at cycle 3
      chk("c0_awready", {31'd0, awready}, 32'd1);
      awaddr = 4'h8; awvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0;
      chk("c1_awready", {31'd0, awready}, 32'd0);
      chk("c1_wready", {31'd0, wready}, 32'd1);
      @(posedge clk); #1;
      chk("c2_awready", {31'd0, awready}, 32'd0);
      @(posedge clk); #1;
      chk("c3_awready", {31'd0, awready}, 32'd0);
      chk("c3_reg2_old", slv_reg2, 32'h3);
      model_write(4'h8, 32'hAABBCCDD, 4'hF);
      bq.push_back(2'b00);
      wdata = 32'hAABBCCDD; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1; wvalid = 1'b0;
      chk("c4_reg2_new", slv_reg2, 32'hAABBCCDD);
      chk("c4_bvalid", {31'd0, bvalid}, 32'd1);
      chk("c4_wready", {31'd0, wready}, 32'd0);
      drain();

      // byte strobes
      axi_write(4'h8, 32'hFFFFFFFF, 4'hF);
      axi_write(4'h8, 32'h12345678, 4'b0101);
      chk("strb_0101", slv_reg2, 32'hFF34FF78);
      axi_write(4'h8, 32'h0BADF00D, 4'b0000);
      chk("strb_0000", slv_reg2, 32'hFF34FF78);
      axi_read(4'h8);
      drain();

      // BREADY stall blocks the next write
      bready = 1'b0;
      axi_write(4'hC, 32'h0000CAFE, 4'hF);
      awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h55; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_bvalid", {31'd0, bvalid}, 32'd1);
         chk("stall_awready", {31'd0, awready}, 32'd0);
         chk("stall_wready", {31'd0, wready}, 32'd0);
      end
      chk("stall_reg0", slv_reg0, 32'h1);
      bready = 1'b1;
      axi_write(4'h0, 32'h00000055, 4'hF);
      drain();
      chk("after_stall_reg0", slv_reg0, 32'h55);
      chk("after_stall_reg3", slv_reg3, 32'hCAFE);

      // RREADY stall holds read data
      rready = 1'b0;
      axi_read(4'hC);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rstall_rvalid", {31'd0, rvalid}, 32'd1);
         chk("rstall_rdata", rdata, 32'hCAFE);
         chk("rstall_arready", {31'd0, arready}, 32'd0);
      end
      rready = 1'b1;
      drain();

      // same-edge read capture and write commit on reg1
      axi_write(4'h4, 32'hA, 4'hF);
      drain();
      rq.push_back(32'hA);
      bq.push_back(2'b00);
      model_write(4'h4, 32'hB, 4'hF);
      awaddr = 4'h4; awvalid = 1'b1; wdata = 32'hB; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 4'h4; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("same_edge_reg1", slv_reg1, 32'hB);
      drain();
      axi_read(4'h4);
      drain();

      // reset while waiting for W
      awaddr = 4'h0; awvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0;
      chk("half_wready", {31'd0, wready}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_awready", {31'd0, awready}, 32'd0);
      chk("arst_wready", {31'd0, wready}, 32'd0);
      chk("arst_arready", {31'd0, arready}, 32'd0);
      chk("arst_reg0", slv_reg0, 32'd0);
      chk("arst_reg1", slv_reg1, 32'd0);
      chk("arst_reg3", slv_reg3, 32'd0);
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_awready", {31'd0, awready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("rel_no_bvalid", {31'd0, bvalid}, 32'd0);
      end
      axi_read(4'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule

// File: doc/alarm_clock_s00_axi.md
ALARM_CLOCK_S00_AXI -- requirements
Module: alarm_clock_s00_axi

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register and data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 registers x 4 bytes).
REQ-003 SHALL have port S_AXI_ACLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR input 4, S_AXI_AWPROT input 3, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1: write address channel.
REQ-006 SHALL have ports S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR input 4, S_AXI_ARPROT input 3, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1: read address channel.
REQ-009 SHALL have ports S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1: read data channel.
REQ-010 SHALL have ports slv_reg0..slv_reg3  output 32 each  current register contents to alarm clock core (reg0 CTRL, reg1 TIME_SET, reg2 ALARM, reg3 SNOOZE).

Function
REQ-011 SHALL decode register index from addr[3:2]; addr[1:0] and AxPROT ignored.
REQ-012 All four registers SHALL be read/write; read returns last written value.
REQ-013 Write FSM SHALL have states W_IDLE, W_HALF, W_RESP.
REQ-014 W_IDLE: AWREADY=1, WREADY=1 (registered outputs); AW and W SHALL be accepted independently, any order or same cycle.
REQ-015 Each channel SHALL capture its payload (AWADDR, or WDATA+WSTRB) on its handshake and drop its READY next cycle; one captured -> W_HALF.
REQ-016 W_HALF: only missing channel READY high; completing handshake -> W_RESP.
REQ-017 In the cycle both payloads are held (T), register SHALL update at end of T, BVALID=1 and BRESP=2'b00 from T+1, both READYs 0.
REQ-018 WSTRB[n]=1 SHALL write byte n; WSTRB=4'b0000 SHALL leave register unchanged but still return OKAY.
REQ-019 W_RESP: BVALID held until BREADY; on B handshake -> W_IDLE, READYs high next cycle; no new AW/W accepted before that.
REQ-020 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-021 AR handshake in cycle T SHALL register RDATA=selected register, RRESP=2'b00, RVALID=1 from T+1.
REQ-022 RDATA/RVALID SHALL be held stable until RREADY; on R handshake -> R_IDLE, ARREADY high next cycle.
REQ-023 Minimum throughput: one write per 3 cycles, one read per 2 cycles; read and write paths SHALL operate concurrently.
REQ-024 Same-edge read capture and write commit to same register: RDATA SHALL return pre-write value.
REQ-025 slv_regN SHALL reflect register contents combinationally from the register flops (no extra delay).
REQ-026 BRESP and RRESP SHALL always be OKAY; no SLVERR/DECERR generated.

Reset
REQ-027 While S_AXI_ARESETN=0: slv_reg0..3=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, FSMs in W_IDLE/R_IDLE.
REQ-028 AWREADY, WREADY, ARREADY SHALL rise at the first rising edge after reset deassertion.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately: no register update, no response issued afterwards.

Verification
REQ-030 Sequential: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB=F), then read back -> RDATA 0x1..0x4, all responses OKAY, slv_reg0..3 match.
REQ-031 AW at cycle 0, W at cycle 3 -> AWREADY low cycles 1-3, register updated end of cycle 3, BVALID at cycle 4.
REQ-032 reg2=0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 -> reg2=0xFF34FF78; WSTRB=0 write -> unchanged, BRESP=0.
REQ-033 BREADY low 5 cycles after write -> BVALID held 5+ cycles, AWREADY/WREADY low, second AW not accepted until after B handshake.
REQ-034 RREADY low 4 cycles -> RDATA stable, ARREADY 0; same-edge read/write to reg1 (old 0xA, new 0xB) -> RDATA=0xA, later read 0xB.
REQ-035 Reset asserted in W_HALF after AW only -> all outputs to reset values asynchronously, registers 0, no BVALID after release.
